// File: rtl/pea_core.sv
// pea_core: polynomial-evaluation accelerator with eight coefficient slots, fed by command/data FIFOs.
// Define PEA_OVERFLOW_DETECT_EN to evaluate in double width and report status 3 on overflow.
module pea_core #(
    parameter int WIDTH = 16,
    parameter int PTR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      command_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             invoke,
    input  logic [1:0]       next_mode_in,
    input  logic [PTR_W-1:0] data_pop,
    input  logic [PTR_W-1:0] command_pop,
    output logic             rd_in_command,
    output logic             rd_in_data,
    output logic             FC,
    output logic             wr_out,
    output logic [WIDTH-1:0] data_out_result,
    output logic [WIDTH-1:0] data_out_status,
    output logic [7:0]       instr,
    output logic [4:0]       arg2
);
`ifdef PEA_OVERFLOW_DETECT_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif
    typedef enum logic [2:0] {IDLE, GC, STP_RD, EVP_LD, EVP_MAC, WRITE, DONE} state_t;
    state_t           r_state, w_next;
    logic [15:0]      r_cmd;
    logic [WIDTH-1:0] r_mem [8][32];
    logic [4:0]       r_deg [8];
    logic [7:0]       r_valid;
    logic [4:0]       r_cnt;
    logic [ACC_W-1:0] r_sum;
    logic             r_ovf;
    logic [7:0]       w_op;
    logic [2:0]       w_slot;
    logic [4:0]       w_a2;
    logic [ACC_W-1:0] w_prod, w_mac;
    logic             w_ovf, w_rdc, w_rdd, w_wr, w_fc;
    logic [WIDTH-1:0] w_result, w_status;
    assign w_op   = r_cmd[15:8];
    assign w_slot = r_cmd[7:5];
    assign w_a2   = r_cmd[4:0];
    assign instr  = w_op;
    assign arg2   = w_a2;
    // One Horner step: sum * x + c_i, with c_i taken highest order first.
    assign w_prod = r_sum * ACC_W'(w_a2);
    assign w_mac  = w_prod + ACC_W'(r_mem[w_slot][r_cnt]);
`ifdef PEA_OVERFLOW_DETECT_EN
    assign w_ovf = (w_prod[ACC_W-1:WIDTH] != '0) || (w_mac[ACC_W-1:WIDTH] != '0);
`else
    assign w_ovf = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !invoke ? IDLE :
                              next_mode_in == 2'd0 ? GC :
                              next_mode_in != 2'd1 ? DONE :
                              w_op == 8'h01 ? STP_RD :
                              (w_op == 8'h02 && r_valid[w_slot]) ? EVP_LD : WRITE;
            GC:      w_next = command_pop != '0 ? DONE : GC;
            STP_RD:  w_next = (data_pop != '0 && r_cnt == '0) ? WRITE : STP_RD;
            EVP_LD:  w_next = EVP_MAC;
            EVP_MAC: w_next = r_cnt == '0 ? WRITE : EVP_MAC;
            WRITE:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_rdc    = r_state == GC && command_pop != '0;
        w_rdd    = r_state == STP_RD && data_pop != '0;
        w_wr     = r_state == WRITE;
        w_fc     = r_state == DONE;
        w_result = (w_op == 8'h02 && r_valid[w_slot]) ? r_sum[WIDTH-1:0] : '0;
        w_status = (w_op == 8'h01 || w_op == 8'h03) ? WIDTH'(0) :
                   w_op != 8'h02 ? WIDTH'(1) :
                   !r_valid[w_slot] ? WIDTH'(2) :
                   r_ovf ? WIDTH'(3) : WIDTH'(0);
    end
    always_ff @(posedge clk) begin
        if (w_rdd) r_mem[w_slot][r_cnt] <= data_in;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_in_command   <= 1'b0;
            rd_in_data      <= 1'b0;
            wr_out          <= 1'b0;
            FC              <= 1'b0;
            data_out_result <= '0;
            data_out_status <= '0;
            r_cmd           <= '0;
            r_valid         <= '0;
            r_deg           <= '{default: '0};
            r_cnt           <= '0;
            r_sum           <= '0;
            r_ovf           <= 1'b0;
        end else begin
            rd_in_command <= w_rdc;
            rd_in_data    <= w_rdd;
            wr_out        <= w_wr;
            FC            <= w_fc;
            if (w_rdc) r_cmd <= command_in;
            if (r_state == IDLE) r_cnt <= w_a2;
            if (r_state == EVP_LD) begin
                r_cnt <= r_deg[w_slot];
                r_sum <= '0;
                r_ovf <= 1'b0;
            end
            if (w_rdd) r_cnt <= r_cnt - 5'd1;
            if (r_state == EVP_MAC) begin
                r_cnt <= r_cnt - 5'd1;
                r_sum <= w_mac;
                r_ovf <= r_ovf | w_ovf;
            end
            if (w_wr) begin
                data_out_result <= w_result;
                data_out_status <= w_status;
                if (w_op == 8'h01) begin
                    r_valid[w_slot] <= 1'b1;
                    r_deg[w_slot]   <= w_a2;
                end
                if (w_op == 8'h03) r_valid[w_slot] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pea_core.sv
// tb_pea_core: directed test of pea_core with queue-modelled first-word-fall-through FIFOs.
module tb_pea_core;
`ifdef PEA_OVERFLOW_DETECT_EN
    localparam logic [15:0] OVF_ST = 16'd3;
`else
    localparam logic [15:0] OVF_ST = 16'd0;
`endif
    logic        clk = 1'b0, rst = 1'b0, invoke = 1'b0;
    logic [1:0]  next_mode_in = 2'd0;
    logic [15:0] command_in = 16'h0, data_in = 16'h0;
    logic [9:0]  data_pop = 10'd0, command_pop = 10'd0;
    logic        rd_in_command, rd_in_data, FC, wr_out;
    logic [15:0] data_out_result, data_out_status;
    logic [7:0]  instr;
    logic [4:0]  arg2;
    logic [15:0] cq[$], dq[$];
    int          n_chk = 0, n_err = 0;
    logic [15:0] res, st;
    int          n_rd, n_wr;
    bit          done;

    pea_core dut (
        .clk(clk), .rst(rst), .command_in(command_in), .data_in(data_in),
        .invoke(invoke), .next_mode_in(next_mode_in), .data_pop(data_pop),
        .command_pop(command_pop), .rd_in_command(rd_in_command), .rd_in_data(rd_in_data),
        .FC(FC), .wr_out(wr_out), .data_out_result(data_out_result),
        .data_out_status(data_out_status), .instr(instr), .arg2(arg2)
    );

    always #5 clk = ~clk;

    // FIFO heads advance once the core flags that it took the word.
    always @(posedge clk) begin
        #1;
        if (rd_in_command && cq.size() > 0) void'(cq.pop_front());
        if (rd_in_data && dq.size() > 0) void'(dq.pop_front());
        command_in  = cq.size() > 0 ? cq[0] : 16'h0;
        data_in     = dq.size() > 0 ? dq[0] : 16'h0;
        command_pop = 10'(cq.size());
        data_pop    = 10'(dq.size());
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [1:0] m);
        @(negedge clk);
        next_mode_in = m;
        invoke = 1'b1;
        @(negedge clk);
        invoke = 1'b0;
    endtask

    task automatic wait_fc(input int budget, output int nr, output int nw,
                           output logic [15:0] r, output logic [15:0] s, output bit d);
        nr = 0; nw = 0; r = '0; s = '0; d = 1'b0;
        for (int i = 0; i < budget && !d; i++) begin
            @(negedge clk);
            if (rd_in_data) nr++;
            if (wr_out) begin
                nw++;
                r = data_out_result;
                s = data_out_status;
            end
            if (FC) d = 1'b1;
        end
    endtask

    task automatic exec(input string tag, input logic [15:0] cmd, output logic [15:0] r,
                        output logic [15:0] s, output int nr, output int nw, output bit d);
        cq.push_back(cmd);
        start(2'd0);
        wait_fc(10, nr, nw, r, s, d);
        check({tag, "_gc_fc"}, 32'(d), 32'd1);
        start(2'd1);
        wait_fc(200, nr, nw, r, s, d);
        check({tag, "_fc"}, 32'(d), 32'd1);
        check({tag, "_nwr"}, 32'(nw), 32'd1);
    endtask

    initial begin
        #1;
        check("rst_fc", 32'(FC), 32'd0);
        check("rst_wr", 32'(wr_out), 32'd0);
        check("rst_rdc", 32'(rd_in_command), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // slot 0 <= 1,2,3,4 (degree 3)
        dq.push_back(16'd1); dq.push_back(16'd2); dq.push_back(16'd3); dq.push_back(16'd4);
        exec("stp0", 16'h0103, res, st, n_rd, n_wr, done);
        check("stp0_instr", 32'(instr), 32'h01);
        check("stp0_arg2", 32'(arg2), 32'd3);
        check("stp0_nrd", 32'(n_rd), 32'd4);
        check("stp0_res", 32'(res), 32'd0);
        check("stp0_st", 32'(st), 32'd0);
        exec("evp0", 16'h0202, res, st, n_rd, n_wr, done);
        check("evp0_res", 32'(res), 32'd26);
        check("evp0_st", 32'(st), 32'd0);
        check("evp0_nrd", 32'(n_rd), 32'd0);
        exec("inval", 16'h0262, res, st, n_rd, n_wr, done);
        check("inval_res", 32'(res), 32'd0);
        check("inval_st", 32'(st), 32'd2);
        exec("op04", 16'h0462, res, st, n_rd, n_wr, done);
        check("op04_st", 32'(st), 32'd1);
        // the word queued here must survive the unknown opcode for the next store
        dq.push_back(16'd5);
        exec("unk", 16'h7F00, res, st, n_rd, n_wr, done);
        check("unk_st", 32'(st), 32'd1);
        check("unk_nrd", 32'(n_rd), 32'd0);
        exec("stp1", 16'h0120, res, st, n_rd, n_wr, done);
        check("stp1_nrd", 32'(n_rd), 32'd1);
        exec("evp1", 16'h0221, res, st, n_rd, n_wr, done);
        check("evp1_res", 32'(res), 32'd5);
        check("evp1_st", 32'(st), 32'd0);
        exec("clr1", 16'h0320, res, st, n_rd, n_wr, done);
        check("clr1_st", 32'(st), 32'd0);
        exec("evp1b", 16'h0221, res, st, n_rd, n_wr, done);
        check("evp1b_res", 32'(res), 32'd0);
        check("evp1b_st", 32'(st), 32'd2);
        // store with only half the data present
        dq.push_back(16'h00FF); dq.push_back(16'h00FF);
        cq.push_back(16'h0143);
        start(2'd0);
        wait_fc(10, n_rd, n_wr, res, st, done);
        check("stall_gc_fc", 32'(done), 32'd1);
        start(2'd1);
        wait_fc(20, n_rd, n_wr, res, st, done);
        check("stall_nofc", 32'(done), 32'd0);
        check("stall_nrd", 32'(n_rd), 32'd2);
        check("stall_nwr", 32'(n_wr), 32'd0);
        dq.push_back(16'h00FF); dq.push_back(16'h00FF);
        wait_fc(20, n_rd, n_wr, res, st, done);
        check("resume_fc", 32'(done), 32'd1);
        check("resume_nrd", 32'(n_rd), 32'd2);
        check("resume_nwr", 32'(n_wr), 32'd1);
        check("resume_st", 32'(st), 32'd0);
        exec("ovf", 16'h025F, res, st, n_rd, n_wr, done);
        check("ovf_res", 32'(res), 32'hC7C0);
        check("ovf_st", 32'(st), 32'(OVF_ST));
        start(2'd2);
        wait_fc(10, n_rd, n_wr, res, st, done);
        check("m2_fc", 32'(done), 32'd1);
        check("m2_nwr", 32'(n_wr), 32'd0);
        start(2'd3);
        wait_fc(10, n_rd, n_wr, res, st, done);
        check("m3_fc", 32'(done), 32'd1);
        check("m3_nwr", 32'(n_wr), 32'd0);
        // reset while the evaluation loop is running
        cq.push_back(16'h0202);
        start(2'd0);
        wait_fc(10, n_rd, n_wr, res, st, done);
        start(2'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_instr", 32'(instr), 32'd0);
        check("arst_arg2", 32'(arg2), 32'd0);
        check("arst_res", 32'(data_out_result), 32'd0);
        check("arst_wr", 32'(wr_out), 32'd0);
        check("arst_fc", 32'(FC), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_fc(10, n_rd, n_wr, res, st, done);
        check("arst_nofc", 32'(done), 32'd0);
        check("arst_nowr", 32'(n_wr), 32'd0);
        exec("post", 16'h0202, res, st, n_rd, n_wr, done);
        check("post_res", 32'(res), 32'd0);
        check("post_st", 32'(st), 32'd2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
